// File: rtl/control_unit_p.sv
// Microprogrammed control unit: 57-bit microword register, 4-way next-address
// select qualified by a status bit. Optional STATE port via CU_STATE_OUT_EN.
module control_unit_p #(
  parameter UCODE_FILE = ""
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IR,
  input  logic        MOC,
  input  logic        COND,
  input  logic        MLS0,
  input  logic        MLS1,
  output logic [31:0] CTL
`ifdef CU_STATE_OUT_EN
  ,
  output logic [7:0]  STATE
`endif
);

  logic [56:0] cr_q, cr_d;
  logic [7:0]  inc_q, inc_d;
  logic [7:0]  enc;
  logic        mux_e;
  logic        sts;
  logic [1:0]  m_sel;
  logic [7:0]  addr;
  logic [56:0] rom_word;

  logic [7:0] f_cr;
  logic [2:0] f_s;
  logic       f_inv;
  logic [2:0] f_n;

  assign f_cr  = cr_q[7:0];
  assign f_s   = cr_q[50:48];
  assign f_inv = cr_q[51];
  assign f_n   = cr_q[56:54];
  assign CTL   = cr_q[39:8];

  // Built-in microprogram; every unlisted word is zero (jump to 0).
  function automatic logic [56:0] dflt_word(input logic [7:0] a);
    logic [56:0] w;
    w = '0;
    case (a)
      8'd0: w[56:54] = 3'b011;
      8'd1: begin
        w[8]      = 1'b1;
        w[56:54]  = 3'b011;
      end
      8'd2: begin
        w[9]      = 1'b1;
        w[50:48]  = 3'b000;
        w[56:54]  = 3'b111;
        w[7:0]    = 8'd2;
      end
      8'd3: begin
        w[10]     = 1'b1;
        w[50:48]  = 3'b001;
        w[51]     = 1'b1;
        w[56:54]  = 3'b110;
      end
      8'd10, 8'd11, 8'd12, 8'd14, 8'd15,
      8'd20, 8'd21, 8'd30, 8'd31: begin
        w[11]     = 1'b1;
        w[39:32]  = a;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  assign rom_word = dflt_word(addr);

  // Instruction decode to execute-routine entry; first match wins.
  always_comb begin
    enc = 8'd0;
    priority case (1'b1)
      (IR[27:25] == 3'b001) && (IR[24:23] == 2'b10): enc = 8'd15;
      (IR[27:25] == 3'b001):                         enc = 8'd11;
      (IR[27:25] == 3'b000) && !IR[4]
        && (IR[24:23] == 2'b10):                     enc = 8'd14;
      (IR[27:25] == 3'b000) && !IR[4]:               enc = 8'd10;
      (IR[27:25] == 3'b000) && !IR[7]:               enc = 8'd12;
      (IR[27:26] == 2'b01):
        enc = IR[20] ? 8'd20 : 8'd21;
      (IR[27:25] == 3'b101):
        enc = IR[24] ? 8'd31 : 8'd30;
      default:                                       enc = 8'd0;
    endcase
  end

  // Status select and qualification.
  always_comb begin
    mux_e = 1'b0;
    case (f_s)
      3'b000:  mux_e = MOC;
      3'b001:  mux_e = COND;
      3'b010:  mux_e = MLS0;
      3'b011:  mux_e = MLS1;
      3'b100:  mux_e = 1'b1;
      default: mux_e = 1'b0;
    endcase
    sts = mux_e ^ f_inv;
  end

  // Next-address mode to source select, then address mux.
  always_comb begin
    m_sel = 2'b00;
    case (f_n)
      3'b000:  m_sel = 2'b00;
      3'b001:  m_sel = 2'b01;
      3'b010:  m_sel = 2'b10;
      3'b011:  m_sel = 2'b11;
      3'b100:  m_sel = sts ? 2'b10 : 2'b11;
      3'b101:  m_sel = sts ? 2'b01 : 2'b11;
      3'b110:  m_sel = sts ? 2'b10 : 2'b01;
      default: m_sel = sts ? 2'b11 : 2'b10;
    endcase
    addr = 8'd0;
    case (m_sel)
      2'b00:   addr = 8'd0;
      2'b01:   addr = enc;
      2'b10:   addr = f_cr;
      default: addr = inc_q;
    endcase
    cr_d  = rom_word;
    inc_d = addr + 8'd1;
  end

  // Control and incrementer registers; reset clears both.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cr_q  <= '0;
      inc_q <= '0;
    end else begin
      cr_q  <= cr_d;
      inc_q <= inc_d;
    end
  end

`ifdef CU_STATE_OUT_EN
  logic [7:0] state_q;
  // Address of the microword currently held.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= '0;
    else       state_q <= addr;
  end
  assign STATE = state_q;
`endif

  logic unused_ok;
  assign unused_ok = ^{cr_q[53:52], cr_q[47:40], IR[31:28],
                       IR[22:21], IR[19:8], IR[6:5], IR[3:0]};

endmodule

// File: tb/tb_control_unit_p.sv
// Bench for control_unit_p: directed scenarios plus random run against a
// state-level model of the default microprogram.
module tb_control_unit_p;

  logic        CLK;
  logic        RESET;
  logic [31:0] IR;
  logic        MOC, COND, MLS0, MLS1;
  logic [31:0] CTL;
`ifdef CU_STATE_OUT_EN
  logic [7:0]  STATE;
`endif

  int n_vec = 0;
  int n_err = 0;
  int st    = -1;

  control_unit_p dut (
    .CLK(CLK), .RESET(RESET), .IR(IR), .MOC(MOC), .COND(COND),
    .MLS0(MLS0), .MLS1(MLS1), .CTL(CTL)
`ifdef CU_STATE_OUT_EN
    , .STATE(STATE)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int dec(input logic [31:0] ir);
    if (ir[27:25] == 3'b001) return (ir[24:23] == 2'b10) ? 15 : 11;
    if (ir[27:25] == 3'b000 && !ir[4])
      return (ir[24:23] == 2'b10) ? 14 : 10;
    if (ir[27:25] == 3'b000 && !ir[7]) return 12;
    if (ir[27:26] == 2'b01) return ir[20] ? 20 : 21;
    if (ir[27:25] == 3'b101) return ir[24] ? 31 : 30;
    return 0;
  endfunction

  // -1 stands for the cleared register held during/just after reset.
  function automatic int nxt(input int s, input logic m, input logic c,
                             input logic [31:0] ir);
    case (s)
      -1: return 0;
      0:  return 1;
      1:  return 2;
      2:  return m ? 3 : 2;
      3:  return c ? dec(ir) : 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ctl_of(input int s);
    logic [7:0] b;
    b = s[7:0];
    case (s)
      1: return 32'h1;
      2: return 32'h2;
      3: return 32'h4;
      10, 11, 12, 14, 15, 20, 21, 30, 31: return {b, 20'h0, 4'h8};
      default: return 32'h0;
    endcase
  endfunction

  task automatic step(input logic r, input logic [31:0] ir,
                      input logic m, input logic c);
    RESET = r; IR = ir; MOC = m; COND = c;
    MLS0 = 1'($urandom); MLS1 = 1'($urandom);
    @(posedge CLK);
    st = r ? -1 : nxt(st, m, c, ir);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'hE1D45004, 1'b1, 1'b1);
      n_vec++;
      if (CTL !== 32'h0) begin
        n_err++;
        $display("FAIL reset_hold CTL=%h exp=%h", CTL, 32'h0);
      end
    end
    step(1'b0, 32'hE1D45004, 1'b1, 1'b1);
    n_vec++;
    if (CTL !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rel0 CTL=%h exp=%h", CTL, 32'h0);
    end
    step(1'b0, 32'hE1D45004, 1'b1, 1'b1);
    n_vec++;
    if (CTL !== 32'h1) begin
      n_err++;
      $display("FAIL reset_rel1 CTL=%h exp=%h", CTL, 32'h1);
    end
  endtask

  task automatic test_fetch_exec();
    logic [31:0] seq [5];
    seq = '{32'h2, 32'h4, 32'h0A000008, 32'h0, 32'h1};
    step(1'b1, 32'hE1D45004, 1'b1, 1'b1);
    step(1'b0, 32'hE1D45004, 1'b1, 1'b1);
    step(1'b0, 32'hE1D45004, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'hE1D45004, 1'b1, 1'b1);
      n_vec++;
      if (CTL !== seq[i] || CTL !== ctl_of(st)) begin
        n_err++;
        $display("FAIL fetch_exec[%0d] CTL=%h exp=%h", i, CTL, seq[i]);
      end
    end
  endtask

  task automatic test_moc_wait();
    step(1'b1, 32'hE1D45004, 1'b0, 1'b1);
    step(1'b0, 32'hE1D45004, 1'b0, 1'b1);
    step(1'b0, 32'hE1D45004, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'hE1D45004, 1'b0, 1'b1);
      n_vec++;
      if (CTL !== 32'h2) begin
        n_err++;
        $display("FAIL moc_wait[%0d] CTL=%h exp=%h", i, CTL, 32'h2);
      end
    end
    step(1'b0, 32'hE1D45004, 1'b1, 1'b1);
    n_vec++;
    if (CTL !== 32'h4) begin
      n_err++;
      $display("FAIL moc_done CTL=%h exp=%h", CTL, 32'h4);
    end
  endtask

  task automatic test_cond_fail();
    step(1'b1, 32'hE1D45004, 1'b1, 1'b0);
    repeat (4) step(1'b0, 32'hE1D45004, 1'b1, 1'b0);
    step(1'b0, 32'hE1D45004, 1'b1, 1'b0);
    n_vec++;
    if (CTL !== 32'h0) begin
      n_err++;
      $display("FAIL cond_fail CTL=%h exp=%h", CTL, 32'h0);
    end
  endtask

  task automatic test_decode();
    logic [31:0] irs [4];
    logic [7:0]  tgt [4];
    irs = '{32'hF29A102C, 32'hF13A102C, 32'hF31A102C, 32'hEA000000};
    tgt = '{8'd11, 8'd14, 8'd15, 8'd30};
    for (int k = 0; k < 4; k++) begin
      step(1'b1, irs[k], 1'b1, 1'b1);
      repeat (5) step(1'b0, irs[k], 1'b1, 1'b1);
      n_vec++;
      if (CTL[31:24] !== tgt[k] || CTL[3] !== 1'b1) begin
        n_err++;
        $display("FAIL decode[%0d] CTL=%h exp_state=%0d", k, CTL, tgt[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 32'hE1D45004, 1'b0, 1'b1);
    repeat (4) step(1'b0, 32'hE1D45004, 1'b0, 1'b1);
    step(1'b1, 32'hE1D45004, 1'b0, 1'b1);
    n_vec++;
    if (CTL !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid CTL=%h exp=%h", CTL, 32'h0);
    end
    step(1'b0, 32'hE1D45004, 1'b1, 1'b1);
    step(1'b0, 32'hE1D45004, 1'b1, 1'b1);
    n_vec++;
    if (CTL !== 32'h1) begin
      n_err++;
      $display("FAIL reset_resume CTL=%h exp=%h", CTL, 32'h1);
    end
  endtask

  task automatic test_random();
    logic [31:0] ir;
    logic        r, m, c;
    step(1'b1, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      ir = $urandom;
      r  = ($urandom_range(0, 31) == 0);
      m  = 1'($urandom);
      c  = ($urandom_range(0, 3) != 0);
      step(r, ir, m, c);
      n_vec++;
      if (CTL !== ctl_of(st)) begin
        n_err++;
        $display("FAIL random[%0d] st=%0d CTL=%h exp=%h",
                 i, st, CTL, ctl_of(st));
      end
`ifdef CU_STATE_OUT_EN
      n_vec++;
      if (STATE !== ((st < 0) ? 8'd0 : st[7:0])) begin
        n_err++;
        $display("FAIL state_out[%0d] STATE=%0d exp=%0d", i, STATE, st);
      end
`endif
    end
  endtask

  initial begin
    RESET = 1'b1; IR = '0; MOC = 1'b0; COND = 1'b0;
    MLS0 = 1'b0; MLS1 = 1'b0;
    test_reset();
    test_fetch_exec();
    test_moc_wait();
    test_cond_fail();
    test_decode();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
